// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
// Contents:
//   AES_ROUNDS     number of round keys after the initial key (10 for AES-128)
//   byte_t/word_t  8-bit byte and 32-bit column word
//   key_cols_t     128-bit key as four column words, index c = column c
//   rcon()         round constant for round 1..10 (0 outside that range)
//   rows_to_cols() row-major ck0..ck3 layout -> column words
//   col_to_row()   column words -> one row-major output word
package aes_pkg;

  localparam int AES_ROUNDS = 10;

  typedef logic [7:0]       byte_t;
  typedef logic [31:0]      word_t;
  typedef logic [3:0][31:0] key_cols_t;

  function automatic byte_t rcon(input logic [3:0] r);
    byte_t rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Row word I carries byte (row I, column c) at bits [31-8c -: 8];
  // column word c is {row0, row1, row2, row3} bytes of that column.
  function automatic key_cols_t rows_to_cols(input word_t r0, input word_t r1,
                                             input word_t r2, input word_t r3);
    key_cols_t k;
    for (int c = 0; c < 4; c++) begin
      k[c] = {r0[31-8*c -: 8], r1[31-8*c -: 8], r2[31-8*c -: 8], r3[31-8*c -: 8]};
    end
    return k;
  endfunction

  function automatic word_t col_to_row(input key_cols_t k, input int row);
    word_t w;
    for (int c = 0; c < 4; c++) begin
      w[31-8*c -: 8] = k[c][31-8*row -: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box.
// Ports:
//   sbox_in   8-bit input byte
//   sbox_out  8-bit substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] sbox_in,
  output logic [7:0] sbox_out
);

  // Entry for input x sits at bits [(255-x)*8 +: 8], i.e. entry 0 is the MSB byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] sbox_idx;

  // (255 - x) * 8 is simply the inverted byte followed by three zero bits.
  assign sbox_idx = {~sbox_in, 3'b000};
  assign sbox_out = SBOX_FLAT[sbox_idx +: 8];

endmodule

// File: rtl/gen_round_key.sv
// AES-128 key-schedule generator. After an accepted start it latches the key
// and presents one round key every ROUND_CYCLES clocks, walking forward
// (round 0 -> 10) in encrypt mode or backward (round 10 -> 0) in decrypt mode.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   encode          direction, sampled at accept (1 = forward, 0 = inverse)
//   start           begin a schedule; ignored while keygening is high
//   ck0..ck3        key rows, byte (row I, column c) at ckI[31-8c -: 8]
//   rko0..rko3      current round key, same row layout
//   keyready        rko holds a valid round key
//   keygening       schedule in progress
//   round           index of the round key on rko (0..10)
module gen_round_key
  import aes_pkg::*;
#(
  parameter int ROUND_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        encode,
  input  logic        start,
  input  logic [31:0] ck0,
  input  logic [31:0] ck1,
  input  logic [31:0] ck2,
  input  logic [31:0] ck3,
  output logic [31:0] rko0,
  output logic [31:0] rko1,
  output logic [31:0] rko2,
  output logic [31:0] rko3,
  output logic        keyready,
  output logic        keygening,
  output logic [3:0]  round
);

  localparam int CNT_W = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROUND_CYCLES - 1);
  localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       round_q, round_d;
  key_cols_t        key_q, key_d;
  logic             dir_q, dir_d;
  logic             keyready_q, keyready_d;

  word_t     w0, w1, w2, w3;
  word_t     v1, v2, v3;
  word_t     sub_src, rot_word, sub_word, rc_word;
  logic [3:0] round_nxt, rc_idx;
  key_cols_t next_key;

  assign w0 = key_q[0];
  assign w1 = key_q[1];
  assign w2 = key_q[2];
  assign w3 = key_q[3];

  // Inverse step recovers the previous round's w1..w3 by XOR-ing neighbours;
  // v3 is the previous w3, which feeds the same SubWord/RotWord path.
  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;

  // One shared SubWord: forward mode transforms w3, inverse mode v3.
  assign sub_src  = dir_q ? w3 : v3;
  assign rot_word = {sub_src[23:0], sub_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .sbox_in  (rot_word[8*i +: 8]),
      .sbox_out (sub_word[8*i +: 8])
    );
  end

  // Forward uses the constant of the round being produced, inverse the
  // constant of the round being undone.
  assign round_nxt = dir_q ? 4'(round_q + 4'd1) : 4'(round_q - 4'd1);
  assign rc_idx    = dir_q ? round_nxt : round_q;
  assign rc_word   = {rcon(rc_idx), 24'h0};

  always_comb begin
    word_t t, n0, n1, n2, n3;
    t  = sub_word ^ rc_word;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    next_key = '0;
    if (dir_q) begin
      next_key[0] = n0;
      next_key[1] = n1;
      next_key[2] = n2;
      next_key[3] = n3;
    end else begin
      next_key[0] = w0 ^ t;
      next_key[1] = v1;
      next_key[2] = v2;
      next_key[3] = v3;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    round_d    = round_q;
    key_d      = key_q;
    dir_d      = dir_q;
    keyready_d = keyready_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RUN;
          dir_d      = encode;
          key_d      = rows_to_cols(ck0, ck1, ck2, ck3);
          round_d    = encode ? 4'd0 : LAST_ROUND;
          cnt_d      = CNT_MAX;
          keyready_d = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          key_d   = next_key;
          round_d = round_nxt;
          cnt_d   = CNT_MAX;
          // Finishing here frees the block for a start on the next cycle;
          // a start seen on this same edge is dropped.
          if (round_nxt == (dir_q ? LAST_ROUND : 4'd0)) begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      round_q    <= '0;
      key_q      <= '0;
      dir_q      <= 1'b0;
      keyready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      round_q    <= round_d;
      key_q      <= key_d;
      dir_q      <= dir_d;
      keyready_q <= keyready_d;
    end
  end

  assign rko0      = col_to_row(key_q, 0);
  assign rko1      = col_to_row(key_q, 1);
  assign rko2      = col_to_row(key_q, 2);
  assign rko3      = col_to_row(key_q, 3);
  assign keyready  = keyready_q;
  assign keygening = (state_q == S_RUN);
  assign round     = round_q;

endmodule

// File: tb/tb_gen_round_key.sv
// Bench for gen_round_key: one instance with ROUND_CYCLES=4 and one with
// ROUND_CYCLES=1, driven with known and random keys and compared against a
// word-array AES-128 key expansion model built from GF(2^8) arithmetic.
module tb_gen_round_key;

  logic        clk = 1'b0;
  logic        rst;
  logic        encode;
  logic        start_a, start_b;
  logic [31:0] ck0, ck1, ck2, ck3;

  logic [31:0] rka0, rka1, rka2, rka3, rkb0, rkb1, rkb2, rkb3;
  logic        ready_a, busy_a, ready_b, busy_b;
  logic [3:0]  round_a, round_b;

  int n_tests = 0;
  int n_fail  = 0;

  bit           sel;
  logic [127:0] obs_key;
  logic         obs_ready, obs_busy;
  logic [3:0]   obs_round;

  logic [31:0]  exp_w [44];
  logic [127:0] cap_r1, cap_r9, enc_r9;

  localparam logic [127:0] KAT_KEY = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] KAT_R1  = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
  localparam logic [127:0] KAT_R10 = 128'hd0c9e1b6_14ee3f63_f9250c0c_a889c8a6;

  always #5 clk = ~clk;

  gen_round_key #(.ROUND_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .encode(encode), .start(start_a),
    .ck0(ck0), .ck1(ck1), .ck2(ck2), .ck3(ck3),
    .rko0(rka0), .rko1(rka1), .rko2(rka2), .rko3(rka3),
    .keyready(ready_a), .keygening(busy_a), .round(round_a)
  );

  gen_round_key #(.ROUND_CYCLES(1)) dut_fast (
    .clk(clk), .rst(rst), .encode(encode), .start(start_b),
    .ck0(ck0), .ck1(ck1), .ck2(ck2), .ck3(ck3),
    .rko0(rkb0), .rko1(rkb1), .rko2(rkb2), .rko3(rkb3),
    .keyready(ready_b), .keygening(busy_b), .round(round_b)
  );

  always_comb begin
    obs_key   = sel ? {rkb0, rkb1, rkb2, rkb3} : {rka0, rka1, rka2, rka3};
    obs_ready = sel ? ready_b : ready_a;
    obs_busy  = sel ? busy_b : busy_a;
    obs_round = sel ? round_b : round_a;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model: GF(2^8) math and textbook word-array expansion ----
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon_ref(input int i);
    logic [7:0] r;
    r = 8'h01;
    for (int k = 1; k < i; k++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [31:0] g_ref(input logic [31:0] w, input int i);
    logic [31:0] rw, sw;
    rw = {w[23:0], w[31:24]};
    for (int b = 0; b < 4; b++) sw[8*b +: 8] = sbox_ref(rw[8*b +: 8]);
    return sw ^ {rcon_ref(i / 4), 24'h0};
  endfunction

  task automatic build_model(input logic [127:0] krows, input bit enc);
    logic [31:0] cols [4];
    logic [31:0] tmp;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        cols[c][31-8*r -: 8] = krows[127-32*r-8*c -: 8];
    if (enc) begin
      for (int c = 0; c < 4; c++) exp_w[c] = cols[c];
      for (int i = 4; i < 44; i++) begin
        tmp = exp_w[i-1];
        if (i % 4 == 0) tmp = g_ref(tmp, i);
        exp_w[i] = exp_w[i-4] ^ tmp;
      end
    end else begin
      for (int c = 0; c < 4; c++) exp_w[40+c] = cols[c];
      for (int i = 43; i >= 4; i--) begin
        tmp = exp_w[i-1];
        if (i % 4 == 0) tmp = g_ref(tmp, i);
        exp_w[i-4] = exp_w[i] ^ tmp;
      end
    end
  endtask

  function automatic logic [127:0] exp_rows(input int rnd);
    logic [127:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-32*r-8*c -: 8] = exp_w[4*rnd+c][31-8*r -: 8];
    return res;
  endfunction

  task automatic drive_start(input bit v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Runs one whole schedule on the selected instance. With inject set, extra
  // starts are pulsed at round 5 and on the completion edge; both must be ignored.
  task automatic do_run(input logic [127:0] krows, input bit enc, input bit inject,
                        input bit hold_after);
    int rc, r;
    rc = sel ? 1 : 4;
    build_model(krows, enc);
    {ck0, ck1, ck2, ck3} = krows;
    encode = enc;
    drive_start(1'b1);
    tick();
    drive_start(1'b0);
    {ck0, ck1, ck2, ck3} = {$urandom, $urandom, $urandom, $urandom};
    encode = ~enc;
    r = enc ? 0 : 10;
    check("acc_round", obs_round, r);
    check("acc_key", obs_key, exp_rows(r));
    check("acc_busy", obs_busy, 1);
    check("acc_ready", obs_ready, 1);
    for (int step = 1; step <= 10; step++) begin
      for (int cyc = 1; cyc <= rc; cyc++) begin
        if (inject && ((cyc == 1 && r == 5) || (step == 10 && cyc == rc))) begin
          {ck0, ck1, ck2, ck3} = {$urandom, $urandom, $urandom, $urandom};
          encode = $urandom_range(0, 1);
          drive_start(1'b1);
        end
        tick();
        drive_start(1'b0);
        if (cyc < rc) check("hold_round", obs_round, r);
      end
      r = enc ? r + 1 : r - 1;
      check("step_round", obs_round, r);
      check("step_key", obs_key, exp_rows(r));
      check("step_busy", obs_busy, step < 10);
      if (r == 1) cap_r1 = obs_key;
      if (r == 9) cap_r9 = obs_key;
    end
    check("done_ready", obs_ready, 1);
    if (hold_after) begin
      tick();
      check("idle_round", obs_round, r);
      check("idle_key", obs_key, exp_rows(r));
      check("idle_busy", obs_busy, 0);
      check("idle_ready", obs_ready, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] rk;
    sel = 1'b0;
    rst = 1'b1;
    encode = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    {ck0, ck1, ck2, ck3} = '0;

    // Reset held two cycles
    tick();
    tick();
    rst = 1'b0;
    check("rst_key", obs_key, 0);
    check("rst_ready", obs_ready, 0);
    check("rst_busy", obs_busy, 0);
    check("rst_round", obs_round, 0);

    // Known-answer encrypt
    do_run(KAT_KEY, 1'b1, 1'b0, 1'b1);
    check("kat_r1", cap_r1, KAT_R1);
    check("kat_r10", obs_key, KAT_R10);
    enc_r9 = cap_r9;

    // Known-answer decrypt from the round-10 key
    do_run(KAT_R10, 1'b0, 1'b0, 1'b1);
    check("dec_r9", cap_r9, enc_r9);
    check("dec_r0", obs_key, KAT_KEY);

    // Ignored starts mid-run and on the completion edge
    do_run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b1, 1'b1);
    do_run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b1);

    // Reset in round 3 aborts the run
    {ck0, ck1, ck2, ck3} = KAT_KEY;
    encode = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (12) tick();
    check("pre_rst_round", obs_round, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_key", obs_key, 0);
    check("abort_ready", obs_ready, 0);
    check("abort_busy", obs_busy, 0);
    check("abort_round", obs_round, 0);
    tick();
    check("abort_idle", obs_busy, 0);
    do_run(KAT_KEY, 1'b1, 1'b0, 1'b1);
    check("rerun_r10", obs_key, KAT_R10);

    // ROUND_CYCLES=1 instance, back-to-back schedules
    sel = 1'b1;
    do_run(KAT_KEY, 1'b1, 1'b0, 1'b0);
    do_run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 1'b0);
    do_run({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b1);

    // Random keys, modes and instances
    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(0, 1);
      rk = {$urandom, $urandom, $urandom, $urandom};
      do_run(rk, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
